// File: rtl/fir_pkg.sv
// Shared constants, state encoding and saturation helper
// for the FIR accumulator and its adder.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Clamp toward the sign of the running accumulator.
  function automatic logic [DATA_W-1:0] sat_value(
    input logic neg
  );
    return neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/cla_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with
// a second lookahead level producing the group carries.
module cla_adder16
  import fir_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] w_g;
  logic [DATA_W-1:0] w_p;
  logic [3:0]        w_gg;
  logic [3:0]        w_gp;
  logic [3:0]        w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2]
                 & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2]
                 & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0]
                 | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1]
                 | (w_gp[1] & w_gg[0])
                 | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2]
                 | (w_gp[2] & w_gg[1])
                 | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0]
                    & i_cin);

  always_comb begin
    logic c;
    o_sum = '0;
    c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = w_gc[k];
      for (int j = 0; j < 4; j++) begin
        o_sum[4*k+j] = w_p[4*k+j] ^ c;
        c = w_g[4*k+j] | (w_p[4*k+j] & c);
      end
    end
  end

endmodule

// File: rtl/fir_accumulator.sv
// Saturating NTAPS-term accumulator with valid/ready
// input and a single registered output slot.
module fir_accumulator
  import fir_pkg::*;
#(
  parameter int NTAPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic [DATA_W-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_sticky;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sat;
  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_last;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_final;

  cla_adder16 u_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  assign w_ovf = (r_acc[DATA_W-1] == in_data[DATA_W-1])
              && (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_result = w_ovf ? sat_value(r_acc[DATA_W-1])
                          : w_sum;

  assign w_last     = (r_cnt == CW'(NTAPS - 1));
  assign out_valid  = (r_state == FULL);
  assign in_ready   = !(w_last && out_valid && !out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  // A term arriving with clr is dropped, so it cannot complete.
  assign w_final    = w_in_fire && w_last && !clr;

  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_final) w_state_nxt = FULL;
      FULL: begin
        if (w_out_fire && !w_final)
          w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_in_fire) begin
      if (w_last) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else begin
        r_acc    <= w_result;
        r_cnt    <= r_cnt + 1'b1;
        r_sticky <= r_sticky | w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_final) begin
      r_out_data <= w_result;
      r_out_sat  <= r_sticky | w_ovf;
    end
  end

endmodule
